// File: rtl/omem_access_ctrl_pkg.sv
// Shared types and sizing for the output-memory access controller.
package omem_access_ctrl_pkg;

    localparam int NUM_SPE     = 5;
    localparam int OUT_DIM     = 21;
    localparam int ADDR_W      = 9;
    localparam int SUM_WIDTH   = 13;
    localparam int NUM_TSTEPS  = 2;
    localparam int NUM_NEURONS = OUT_DIM * OUT_DIM;

    // Identifier of the output memory within the accelerator's memory set.
    localparam logic [3:0] OMEM_ID = 4'h1;

    localparam int IDX_W = (NUM_SPE > 1) ? $clog2(NUM_SPE) : 1;
    localparam int CNT_W = $clog2(NUM_NEURONS + 1);
    localparam int TS_W  = (NUM_TSTEPS > 1) ? $clog2(NUM_TSTEPS) : 1;

    typedef enum logic {
        OP_WRITE_POT = 1'b0,
        OP_READ_PREV = 1'b1
    } op_e;

    typedef enum logic [1:0] {
        ARB     = 2'd0,
        RD_WAIT = 2'd1,
        RD_RSP  = 2'd2
    } state_e;

    // Expand a requester index into its one-hot position.
    function automatic logic [NUM_SPE-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
        logic [NUM_SPE-1:0] oh;
        for (int i = 0; i < NUM_SPE; i++) begin
            oh[i] = (idx == IDX_W'(i));
        end
        return oh;
    endfunction

endpackage

// File: rtl/omem_access_ctrl_if.sv
// Bundle of SPE request/response, OMEM port and timestep status signals.
interface omem_access_ctrl_if #(
    parameter int N  = omem_access_ctrl_pkg::NUM_SPE,
    parameter int AW = omem_access_ctrl_pkg::ADDR_W,
    parameter int SW = omem_access_ctrl_pkg::SUM_WIDTH
);
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N-1:0]    req_op;
    logic [N*AW-1:0] req_addr;
    logic [N*SW-1:0] req_wdata;
    logic [N-1:0]    req_spike;
    logic [N-1:0]    rsp_valid;
    logic [N-1:0]    rsp_ready;
    logic [SW-1:0]   rsp_data;
    logic            mem_en;
    logic            mem_we;
    logic [AW-1:0]   mem_addr;
    logic [SW:0]     mem_wdata;
    logic [SW:0]     mem_rdata;
    logic            first_tstep;
    logic            tstep_done;

    // Controller side.
    modport slave (
        input  req_valid, req_op, req_addr, req_wdata, req_spike, rsp_ready, mem_rdata,
        output req_ready, rsp_valid, rsp_data, mem_en, mem_we, mem_addr, mem_wdata,
               first_tstep, tstep_done
    );

    // Requesters plus memory side.
    modport master (
        output req_valid, req_op, req_addr, req_wdata, req_spike, rsp_ready, mem_rdata,
        input  req_ready, rsp_valid, rsp_data, mem_en, mem_we, mem_addr, mem_wdata,
               first_tstep, tstep_done
    );
endinterface

// File: rtl/omem_access_ctrl_rr_arbiter.sv
// Round-robin arbiter: combinational grant starting at the pointer, pointer
// advances past the granted requester whenever a grant is issued.
module omem_access_ctrl_rr_arbiter #(
    parameter int N  = 5,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [N-1:0]  req,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx,
    output logic          grant_vld
);
    localparam logic [IW:0] N_L = (IW + 1)'(N);

    logic [IW-1:0] ptr_r;
    logic [IW:0]   sum_s;
    logic [IW:0]   cand_s;
    logic [IW-1:0] grant_idx_s;
    logic          grant_vld_s;
    logic [N-1:0]  grant_s;

    // Search requesters starting at the pointer, wrapping N-1 -> 0.
    always_comb begin
        sum_s       = '0;
        cand_s      = '0;
        grant_idx_s = '0;
        grant_vld_s = 1'b0;
        for (int k = 0; k < N; k++) begin
            sum_s  = {1'b0, ptr_r} + (IW + 1)'(k);
            cand_s = (sum_s >= N_L) ? (sum_s - N_L) : sum_s;
            if (en && !grant_vld_s && req[cand_s[IW-1:0]]) begin
                grant_vld_s = 1'b1;
                grant_idx_s = cand_s[IW-1:0];
            end else begin
                grant_vld_s = grant_vld_s;
            end
        end
    end

    // Expand the winning index into the one-hot grant vector.
    always_comb begin
        grant_s = '0;
        for (int i = 0; i < N; i++) begin
            grant_s[i] = grant_vld_s && (grant_idx_s == IW'(i));
        end
    end

    // Pointer moves to the requester after the one just granted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_r <= '0;
        end else if (grant_vld_s) begin
            ptr_r <= (grant_idx_s == IW'(N - 1)) ? '0 : (grant_idx_s + IW'(1));
        end else begin
            ptr_r <= ptr_r;
        end
    end

    assign grant     = grant_s;
    assign grant_idx = grant_idx_s;
    assign grant_vld = grant_vld_s;

endmodule

// File: rtl/omem_access_ctrl.sv
// Output-memory access controller: arbitrates the single OMEM port among the
// sum PEs, sequences reads back to their requester, and tracks timesteps.
module omem_access_ctrl
    import omem_access_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    omem_access_ctrl_if.slave  bus
);
    state_e                 state_r;
    state_e                 state_nxt_s;
    logic                   arb_en_s;
    logic [NUM_SPE-1:0]     grant_s;
    logic [IDX_W-1:0]       grant_idx_s;
    logic                   grant_vld_s;
    logic                   grant_op_s;
    logic                   wr_accept_s;
    logic                   rd_accept_s;
    logic                   rsp_hs_s;
    logic                   last_wr_s;
    logic [TS_W-1:0]        tstep_nxt_s;

    logic                   mem_en_s;
    logic                   mem_we_s;
    logic [ADDR_W-1:0]      mem_addr_s;
    logic [SUM_WIDTH:0]     mem_wdata_s;

    logic [IDX_W-1:0]       rsp_idx_r;
    logic [SUM_WIDTH-1:0]   rsp_data_r;
    logic [NUM_SPE-1:0]     rsp_valid_r;
    logic [CNT_W-1:0]       wr_cnt_r;
    logic [TS_W-1:0]        tstep_r;
    logic                   first_tstep_r;
    logic                   tstep_done_r;

    // Grants only in ARB; held off while reset is applied so nothing is
    // accepted before the controller is running.
    assign arb_en_s = (state_r == ARB) && !rst;

    omem_access_ctrl_rr_arbiter #(
        .N (NUM_SPE)
    ) u_arb (
        .clk       (clk),
        .rst       (rst),
        .en        (arb_en_s),
        .req       (bus.req_valid),
        .grant     (grant_s),
        .grant_idx (grant_idx_s),
        .grant_vld (grant_vld_s)
    );

    assign grant_op_s  = bus.req_op[grant_idx_s];
    assign wr_accept_s = grant_vld_s && (grant_op_s == OP_WRITE_POT);
    assign rd_accept_s = grant_vld_s && (grant_op_s == OP_READ_PREV);
    assign rsp_hs_s    = (state_r == RD_RSP) && bus.rsp_ready[rsp_idx_r] && rsp_valid_r[rsp_idx_r];
    assign last_wr_s   = (wr_cnt_r == CNT_W'(NUM_NEURONS - 1));

    // Drive the OMEM port from the granted requester in its grant cycle.
    always_comb begin
        mem_en_s    = 1'b0;
        mem_we_s    = 1'b0;
        mem_addr_s  = '0;
        mem_wdata_s = '0;
        if (grant_vld_s) begin
            mem_en_s    = 1'b1;
            mem_we_s    = wr_accept_s;
            mem_addr_s  = bus.req_addr[grant_idx_s*ADDR_W +: ADDR_W];
            mem_wdata_s = wr_accept_s ?
                          {bus.req_spike[grant_idx_s], bus.req_wdata[grant_idx_s*SUM_WIDTH +: SUM_WIDTH]} :
                          '0;
        end else begin
            mem_en_s = 1'b0;
        end
    end

    // Next-state logic for the read sequencing FSM.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ARB: begin
                if (rd_accept_s) begin
                    state_nxt_s = RD_WAIT;
                end else begin
                    state_nxt_s = ARB;
                end
            end
            RD_WAIT: state_nxt_s = RD_RSP;
            RD_RSP: begin
                if (rsp_hs_s) begin
                    state_nxt_s = ARB;
                end else begin
                    state_nxt_s = RD_RSP;
                end
            end
            default: state_nxt_s = ARB;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ARB;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Remember the reader, capture memory data and present the response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_idx_r   <= '0;
            rsp_data_r  <= '0;
            rsp_valid_r <= '0;
        end else begin
            if (rd_accept_s) begin
                rsp_idx_r <= grant_idx_s;
            end else begin
                rsp_idx_r <= rsp_idx_r;
            end
            if (state_r == RD_WAIT) begin
                rsp_data_r  <= bus.mem_rdata[SUM_WIDTH-1:0];
                rsp_valid_r <= idx_to_onehot(rsp_idx_r);
            end else if (rsp_hs_s) begin
                rsp_valid_r <= '0;
            end else begin
                rsp_valid_r <= rsp_valid_r;
            end
        end
    end

    // Timestep index following the current one, wrapping after the last.
    always_comb begin
        tstep_nxt_s = '0;
        if (tstep_r == TS_W'(NUM_TSTEPS - 1)) begin
            tstep_nxt_s = '0;
        end else begin
            tstep_nxt_s = tstep_r + TS_W'(1);
        end
    end

    // Count neuron writes; the write completing the map closes the timestep.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_cnt_r      <= '0;
            tstep_r       <= '0;
            first_tstep_r <= 1'b1;
            tstep_done_r  <= 1'b0;
        end else if (wr_accept_s && last_wr_s) begin
            wr_cnt_r      <= '0;
            tstep_r       <= tstep_nxt_s;
            first_tstep_r <= (tstep_nxt_s == '0);
            tstep_done_r  <= 1'b1;
        end else if (wr_accept_s) begin
            wr_cnt_r      <= wr_cnt_r + CNT_W'(1);
            tstep_done_r  <= 1'b0;
        end else begin
            tstep_done_r  <= 1'b0;
        end
    end

    assign bus.req_ready   = grant_s;
    assign bus.mem_en      = mem_en_s;
    assign bus.mem_we      = mem_we_s;
    assign bus.mem_addr    = mem_addr_s;
    assign bus.mem_wdata   = mem_wdata_s;
    assign bus.rsp_valid   = rsp_valid_r;
    assign bus.rsp_data    = rsp_data_r;
    assign bus.first_tstep = first_tstep_r;
    assign bus.tstep_done  = tstep_done_r;

endmodule

// File: tb/tb_omem_access_ctrl.sv
// Directed self-checking bench for the OMEM access controller.
module tb_omem_access_ctrl;
    import omem_access_ctrl_pkg::*;

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    int   wr_total;

    omem_access_ctrl_if bus ();

    omem_access_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.req_valid = 5'b00000;
        bus.req_op    = 5'b00000;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.req_spike = 5'b00000;
        bus.rsp_ready = 5'b00000;
        bus.mem_rdata = 14'h0000;
    endtask

    task automatic set_req(input int i, input logic op, input logic [8:0] addr,
                           input logic [12:0] wdata, input logic spike);
        bus.req_valid[i] = 1'b1;
        bus.req_op[i]    = op;
        bus.req_addr[i*ADDR_W +: ADDR_W]       = addr;
        bus.req_wdata[i*SUM_WIDTH +: SUM_WIDTH] = wdata;
        bus.req_spike[i] = spike;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        bus.req_valid = 5'b11111;
        tick();
        tick();
        @(negedge clk);
        checks++;
        if (bus.req_ready !== 5'b00000) begin
            failures++;
            $display("FAIL reset_req_ready: got %b expected %b", bus.req_ready, 5'b00000);
        end
        checks++;
        if (bus.first_tstep !== 1'b1) begin
            failures++;
            $display("FAIL reset_first_tstep: got %b expected %b", bus.first_tstep, 1'b1);
        end
        checks++;
        if (bus.mem_en !== 1'b0 || bus.rsp_valid !== 5'b00000 || bus.tstep_done !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs: got mem_en=%b rsp_valid=%b tstep_done=%b expected 0/00000/0",
                     bus.mem_en, bus.rsp_valid, bus.tstep_done);
        end
        bus.req_valid = 5'b00000;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_rr_fairness();
        logic [4:0]  exp_grant [6] = '{5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b10000, 5'b00001};
        logic [8:0]  exp_addr  [6] = '{9'd1, 9'd11, 9'd21, 9'd31, 9'd41, 9'd1};
        logic [13:0] exp_wdata [6] = '{14'h0007, 14'h206B, 14'h00CF, 14'h2133, 14'h0197, 14'h0007};
        // SPE i: addr 10*i+1, wdata 100*i+7, spike = i odd
        for (int i = 0; i < 5; i++) begin
            set_req(i, OP_WRITE_POT, 9'(10 * i + 1), 13'(100 * i + 7), (i % 2) == 1);
        end
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            checks++;
            if (bus.req_ready !== exp_grant[c]) begin
                failures++;
                $display("FAIL rr_grant[%0d]: got %b expected %b", c, bus.req_ready, exp_grant[c]);
            end
            checks++;
            if (bus.mem_en !== 1'b1 || bus.mem_we !== 1'b1 || bus.mem_addr !== exp_addr[c]
                || bus.mem_wdata !== exp_wdata[c]) begin
                failures++;
                $display("FAIL rr_mem[%0d]: got en=%b we=%b addr=%0d wdata=%h expected 1/1/%0d/%h",
                         c, bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata, exp_addr[c], exp_wdata[c]);
            end
            tick();
            wr_total++;
        end
        clear_inputs();
    endtask

    task automatic test_read();
        // pointer is at 1; SPE2 read wins over SPE0 write pending
        set_req(2, OP_READ_PREV, 9'd37, 13'd0, 1'b0);
        set_req(0, OP_WRITE_POT, 9'd100, 13'd5, 1'b0);
        @(negedge clk);
        checks++;
        if (bus.req_ready !== 5'b00100 || bus.mem_en !== 1'b1 || bus.mem_we !== 1'b0
            || bus.mem_addr !== 9'd37) begin
            failures++;
            $display("FAIL read_issue: got ready=%b en=%b we=%b addr=%0d expected 00100/1/0/37",
                     bus.req_ready, bus.mem_en, bus.mem_we, bus.mem_addr);
        end
        tick();
        bus.req_valid[2] = 1'b0;
        bus.mem_rdata = 14'h0055;
        @(negedge clk);
        checks++;
        if (bus.req_ready !== 5'b00000 || bus.mem_en !== 1'b0 || bus.rsp_valid !== 5'b00000) begin
            failures++;
            $display("FAIL read_wait: got ready=%b en=%b rsp_valid=%b expected 00000/0/00000",
                     bus.req_ready, bus.mem_en, bus.rsp_valid);
        end
        tick();
        bus.mem_rdata = 14'h3FFF;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (bus.rsp_valid !== 5'b00100 || bus.rsp_data !== 13'h0055 || bus.req_ready !== 5'b00000) begin
                failures++;
                $display("FAIL read_hold[%0d]: got rsp_valid=%b data=%h ready=%b expected 00100/0055/00000",
                         c, bus.rsp_valid, bus.rsp_data, bus.req_ready);
            end
            tick();
        end
        bus.rsp_ready = 5'b00100;
        @(negedge clk);
        checks++;
        if (bus.rsp_valid !== 5'b00100 || bus.req_ready !== 5'b00000) begin
            failures++;
            $display("FAIL read_handshake: got rsp_valid=%b ready=%b expected 00100/00000",
                     bus.rsp_valid, bus.req_ready);
        end
        tick();
        bus.rsp_ready = 5'b00000;
        @(negedge clk);
        checks++;
        if (bus.rsp_valid !== 5'b00000 || bus.req_ready !== 5'b00001 || bus.mem_we !== 1'b1) begin
            failures++;
            $display("FAIL read_release: got rsp_valid=%b ready=%b we=%b expected 00000/00001/1",
                     bus.rsp_valid, bus.req_ready, bus.mem_we);
        end
        tick();
        wr_total++;
        clear_inputs();
    endtask

    task automatic test_read_while_waiting();
        // pointer is at 1: SPE1 read beats the SPE3 write
        set_req(1, OP_READ_PREV, 9'd200, 13'd0, 1'b0);
        set_req(3, OP_WRITE_POT, 9'd201, 13'd9, 1'b1);
        @(negedge clk);
        checks++;
        if (bus.req_ready !== 5'b00010 || bus.mem_we !== 1'b0) begin
            failures++;
            $display("FAIL rww_first: got ready=%b we=%b expected 00010/0", bus.req_ready, bus.mem_we);
        end
        tick();
        bus.req_valid[1] = 1'b0;
        bus.mem_rdata = 14'h3ABC;
        tick();
        bus.rsp_ready = 5'b00010;
        @(negedge clk);
        checks++;
        if (bus.rsp_valid !== 5'b00010 || bus.rsp_data !== 13'h1ABC || bus.req_ready !== 5'b00000) begin
            failures++;
            $display("FAIL rww_rsp: got rsp_valid=%b data=%h ready=%b expected 00010/1abc/00000",
                     bus.rsp_valid, bus.rsp_data, bus.req_ready);
        end
        tick();
        bus.rsp_ready = 5'b00000;
        @(negedge clk);
        checks++;
        if (bus.req_ready !== 5'b01000 || bus.mem_we !== 1'b1 || bus.mem_wdata !== 14'h2009) begin
            failures++;
            $display("FAIL rww_second: got ready=%b we=%b wdata=%h expected 01000/1/2009",
                     bus.req_ready, bus.mem_we, bus.mem_wdata);
        end
        tick();
        wr_total++;
        clear_inputs();
    endtask

    task automatic run_timestep(input int n, input logic exp_first);
        int spurious;
        spurious = 0;
        set_req(0, OP_WRITE_POT, 9'd3, 13'd1, 1'b0);
        for (int k = 1; k <= n; k++) begin
            tick();
            if (k < n && bus.tstep_done !== 1'b0) spurious++;
            if (k == n - 1) begin
                checks++;
                if (bus.first_tstep !== !exp_first) begin
                    failures++;
                    $display("FAIL tstep_before: got first_tstep=%b expected %b", bus.first_tstep, !exp_first);
                end
            end
        end
        bus.req_valid = 5'b00000;
        checks++;
        if (bus.tstep_done !== 1'b1 || bus.first_tstep !== exp_first) begin
            failures++;
            $display("FAIL tstep_pulse: got done=%b first=%b expected 1/%b",
                     bus.tstep_done, bus.first_tstep, exp_first);
        end
        checks++;
        if (spurious !== 0) begin
            failures++;
            $display("FAIL tstep_early: got %0d early pulses expected 0", spurious);
        end
        tick();
        checks++;
        if (bus.tstep_done !== 1'b0 || bus.first_tstep !== exp_first) begin
            failures++;
            $display("FAIL tstep_after: got done=%b first=%b expected 0/%b",
                     bus.tstep_done, bus.first_tstep, exp_first);
        end
        wr_total += n;
    endtask

    task automatic test_timestep();
        run_timestep(NUM_NEURONS - (wr_total % NUM_NEURONS), 1'b0);
        run_timestep(NUM_NEURONS, 1'b1);
        clear_inputs();
    endtask

    task automatic test_reset_mid_read();
        set_req(4, OP_READ_PREV, 9'd5, 13'd0, 1'b0);
        bus.mem_rdata = 14'h0123;
        tick();
        bus.req_valid = 5'b00000;
        tick();
        checks++;
        if (bus.rsp_valid !== 5'b10000 || bus.rsp_data !== 13'h0123) begin
            failures++;
            $display("FAIL rmr_rsp: got rsp_valid=%b data=%h expected 10000/0123", bus.rsp_valid, bus.rsp_data);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (bus.rsp_valid !== 5'b00000 || bus.req_ready !== 5'b00000) begin
            failures++;
            $display("FAIL rmr_abort: got rsp_valid=%b ready=%b expected 00000/00000",
                     bus.rsp_valid, bus.req_ready);
        end
        set_req(3, OP_WRITE_POT, 9'd7, 13'd2, 1'b0);
        set_req(0, OP_WRITE_POT, 9'd8, 13'd3, 1'b0);
        tick();
        tick();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.req_ready !== 5'b00001 || bus.mem_we !== 1'b1 || bus.mem_addr !== 9'd8) begin
            failures++;
            $display("FAIL rmr_fresh: got ready=%b we=%b addr=%0d expected 00001/1/8",
                     bus.req_ready, bus.mem_we, bus.mem_addr);
        end
        checks++;
        if (bus.first_tstep !== 1'b1 || bus.tstep_done !== 1'b0) begin
            failures++;
            $display("FAIL rmr_status: got first=%b done=%b expected 1/0", bus.first_tstep, bus.tstep_done);
        end
        tick();
        clear_inputs();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        wr_total = 0;
        rst      = 1'b1;
        clear_inputs();
        test_reset();
        test_rr_fairness();
        test_read();
        test_read_while_waiting();
        test_timestep();
        test_reset_mid_read();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
